// File: rtl/prio_enc_queue.sv
// Registered priority-encoder queue: accumulates request pulses and emits one index per valid/ready transfer.
// Optional macro ROUND_ROBIN_EN replaces the fixed highest-index-wins rule with a rotating pointer.
module prio_enc_queue #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] pending,
    output logic         idle
);

    logic         free;
    logic         has_sel;
    logic         load;
    logic [W-1:0] sel;
    logic [N-1:0] clear_mask;

    assign free    = !out_valid || out_ready;
    assign has_sel = |pending;
    assign load    = free && has_sel;
    assign idle    = (pending == '0) && !out_valid;

`ifdef ROUND_ROBIN_EN
    logic [W-1:0] ptr;

    // Search upward from ptr, wrapping past N-1 back to 0.
    always_comb begin
        logic found;
        int   idx;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && pending[idx]) begin
                sel   = W'(idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= (int'(sel) == N - 1) ? '0 : sel + W'(1);
        end
    end
`else
    // Later iterations overwrite earlier ones, so the highest set index wins.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++) begin
            if (pending[i]) sel = W'(i);
        end
    end
`endif

    always_comb begin
        clear_mask = '0;
        if (load) clear_mask[sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: synchronous reset covers every register here; there is no memory array to exempt.
        if (rst) begin
            pending   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            // OR-ing req after the clear makes a simultaneous set win over the clear.
            pending <= (pending & ~clear_mask) | req;
            if (free) begin
                out_valid <= has_sel;
                if (has_sel) out_idx <= sel;
            end
        end
    end

endmodule

// File: tb/tb_prio_enc_queue.sv
// Directed self-checking bench for prio_enc_queue with N=4.
// Fixed-priority expectations by default; round-robin expectations when ROUND_ROBIN_EN is defined.
module tb_prio_enc_queue;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [W-1:0] out_idx;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] pending;
    logic         idle;

    int n_checks = 0;
    int n_fail   = 0;

    prio_enc_queue #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle; outputs are sampled and inputs driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; out_ready = 1'b1;
        tick();
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_checks++; if (out_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", out_idx); end
        n_checks++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending got %b want 0000", pending); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b want 1", idle); end
        rst = 1'b0; req = 4'b0000;
        tick();
        n_checks++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL release_pending got %b want 0000", pending); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL release_idle got %b want 1", idle); end
    endtask

    task automatic test_single_pulse();
        out_ready = 1'b1; req = 4'b0100;
        tick();
        req = 4'b0000;
        n_checks++; if (pending !== 4'b0100) begin n_fail++; $display("FAIL pulse_pending got %b want 0100", pending); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pulse_early_valid got %b want 0", out_valid); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_idx !== 2'd2) begin n_fail++; $display("FAIL pulse_out got v=%b idx=%0d want v=1 idx=2", out_valid, out_idx); end
        n_checks++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL pulse_cleared got %b want 0000", pending); end
        tick();
        n_checks++; if (out_valid !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL pulse_drain got v=%b idle=%b want v=0 idle=1", out_valid, idle); end
        n_checks++; if (out_idx !== 2'd2) begin n_fail++; $display("FAIL pulse_idx_hold got %0d want 2", out_idx); end
    endtask

    task automatic test_burst();
        logic [W-1:0] exp_seq [3];
`ifdef ROUND_ROBIN_EN
        // ptr is 3 after the single pulse on line 2.
        exp_seq[0] = 2'd3; exp_seq[1] = 2'd0; exp_seq[2] = 2'd1;
`else
        exp_seq[0] = 2'd3; exp_seq[1] = 2'd1; exp_seq[2] = 2'd0;
`endif
        out_ready = 1'b1; req = 4'b1011;
        tick();
        req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_idx !== exp_seq[i]) begin
                n_fail++; $display("FAIL burst_%0d got v=%b idx=%0d want v=1 idx=%0d", i, out_valid, out_idx, exp_seq[i]);
            end
        end
        tick();
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL burst_idle got %b want 1", idle); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; req = 4'b1000;
        tick();
        req = 4'b0000;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_idx !== 2'd3) begin n_fail++; $display("FAIL bp_load got v=%b idx=%0d want v=1 idx=3", out_valid, out_idx); end
        for (int i = 0; i < 5; i++) begin
            req = (i % 2 == 0) ? 4'b1000 : 4'b0000;
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_idx !== 2'd3) begin
                n_fail++; $display("FAIL bp_stall_%0d got v=%b idx=%0d want v=1 idx=3", i, out_valid, out_idx);
            end
        end
        n_checks++; if (pending[3] !== 1'b1) begin n_fail++; $display("FAIL bp_repend got %b want 1", pending[3]); end
        req = 4'b0000; out_ready = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_idx !== 2'd3 || pending !== 4'b0000) begin
            n_fail++; $display("FAIL bp_reemit got v=%b idx=%0d p=%b want v=1 idx=3 p=0000", out_valid, out_idx, pending);
        end
        tick();
        n_checks++; if (out_valid !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL bp_done got v=%b idle=%b want v=0 idle=1", out_valid, idle); end
    endtask

    task automatic test_collision();
        out_ready = 1'b1; req = 4'b0010;
        tick();
        tick();
        req = 4'b0000;
        n_checks++; if (out_valid !== 1'b1 || out_idx !== 2'd1) begin n_fail++; $display("FAIL coll_load got v=%b idx=%0d want v=1 idx=1", out_valid, out_idx); end
        n_checks++; if (pending[1] !== 1'b1) begin n_fail++; $display("FAIL coll_set_wins got %b want 1", pending[1]); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_idx !== 2'd1 || pending !== 4'b0000) begin
            n_fail++; $display("FAIL coll_reemit got v=%b idx=%0d p=%b want v=1 idx=1 p=0000", out_valid, out_idx, pending);
        end
        tick();
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL coll_idle got %b want 1", idle); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1; req = 4'b1111;
        tick();
        req = 4'b0000;
        tick();
        tick();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b want 1", out_valid); end
        rst = 1'b1; req = 4'b0001;
        tick();
        n_checks++; if (out_valid !== 1'b0 || pending !== 4'b0000 || out_idx !== 2'd0 || idle !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset got v=%b p=%b idx=%0d idle=%b want 0 0000 0 1", out_valid, pending, out_idx, idle);
        end
        rst = 1'b0; req = 4'b0000;
        tick();
    endtask

`ifdef ROUND_ROBIN_EN
    task automatic test_round_robin();
        out_ready = 1'b1; req = 4'b1111;
        tick();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) req = 4'b0000;
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_idx !== W'(i % 4)) begin
                n_fail++; $display("FAIL rr_%0d got v=%b idx=%0d want v=1 idx=%0d", i, out_valid, out_idx, i % 4);
            end
        end
        req = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; req = '0; out_ready = 1'b0;
        test_reset();
        test_single_pulse();
        test_burst();
        test_backpressure();
        test_collision();
        test_mid_reset();
`ifdef ROUND_ROBIN_EN
        test_round_robin();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
